core_en_sequencer: RTL and testbench

CORE_EN_SEQUENCER -- requirements
Module: core_en_sequencer

---
 rtl/core_en_sequencer.sv | 134 +++++++++++++
 tb/tb_core_en_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_en_sequencer.sv
`timescale 1ns / 1ps
// core_en_sequencer: walks core_en_o toward target_i one bit at a time,
// disables before enables, with a fixed settle gap after every change.
// kill_i forces every enable off and abandons any settle wait.
module core_en_sequencer #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned GAP_CYCLES = 8,
  localparam int unsigned IDX_W = ($clog2(NUM_CORES) > 0) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_CORES-1:0] target_i,
  input  logic                 hold_i,
  input  logic                 kill_i,
  output logic [NUM_CORES-1:0] core_en_o,
  output logic                 busy_o,
  output logic                 step_o,
  output logic [IDX_W-1:0]     step_idx_o,
  output logic                 step_on_o
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_CORES-1:0] r_core_en;
  logic                 r_step;
  logic [IDX_W-1:0]     r_step_idx;
  logic                 r_step_on;

  state_e               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_CORES-1:0] w_core_en_nxt;
  logic                 w_step_nxt;
  logic [IDX_W-1:0]     w_step_idx_nxt;
  logic                 w_step_on_nxt;

  logic [NUM_CORES-1:0] w_dis;
  logic [NUM_CORES-1:0] w_ena;
  logic [IDX_W-1:0]     w_dis_idx;
  logic [IDX_W-1:0]     w_ena_idx;
  logic                 w_start;

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Pending work: cores to switch off and cores to switch on.
  always_comb begin
    w_dis     = r_core_en & ~target_i;
    w_ena     = ~r_core_en & target_i;
    w_dis_idx = lowest_set(w_dis);
    w_ena_idx = lowest_set(w_ena);
  end

  // Next-state logic: kill overrides everything, then IDLE stepping or WAIT countdown.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_core_en_nxt  = r_core_en;
    w_step_nxt     = 1'b0;
    w_step_idx_nxt = r_step_idx;
    w_step_on_nxt  = r_step_on;
    w_start        = 1'b0;

    if (kill_i) begin
      w_core_en_nxt = '0;
      w_cnt_nxt     = '0;
      w_state_nxt   = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!hold_i) begin
            if (|w_dis) begin
              w_core_en_nxt[w_dis_idx] = 1'b0;
              w_step_idx_nxt           = w_dis_idx;
              w_step_on_nxt            = 1'b0;
              w_start                  = 1'b1;
            end else if (|w_ena) begin
              w_core_en_nxt[w_ena_idx] = 1'b1;
              w_step_idx_nxt           = w_ena_idx;
              w_step_on_nxt            = 1'b1;
              w_start                  = 1'b1;
            end
          end
          if (w_start) begin
            w_step_nxt  = 1'b1;
            w_cnt_nxt   = CNT_W'(GAP_CYCLES);
            w_state_nxt = StWait;
          end
        end
        StWait: begin
          // hold_i deliberately ignored here: the settle time keeps running.
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_core_en  <= '0;
      r_step     <= 1'b0;
      r_step_idx <= '0;
      r_step_on  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_core_en  <= w_core_en_nxt;
      r_step     <= w_step_nxt;
      r_step_idx <= w_step_idx_nxt;
      r_step_on  <= w_step_on_nxt;
    end
  end

  assign core_en_o  = r_core_en;
  assign busy_o     = (r_state == StWait);
  assign step_o     = r_step;
  assign step_idx_o = r_step_idx;
  assign step_on_o  = r_step_on;

endmodule

// File: tb/tb_core_en_sequencer.sv
`timescale 1ns / 1ps
// Bench for core_en_sequencer: timestamp-based reference model checked every
// cycle, plus a table of hand-computed expectations pinned to absolute cycles.
module tb_core_en_sequencer;
  localparam int unsigned NC  = 4;
  localparam int unsigned GAP = 8;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic [NC-1:0] target = '0;
  logic          hold   = 1'b0;
  logic          kill   = 1'b0;
  logic [NC-1:0] core_en;
  logic          busy;
  logic          step;
  logic [1:0]    step_idx;
  logic          step_on;

  core_en_sequencer #(
    .NUM_CORES (NC),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .target_i  (target),
    .hold_i    (hold),
    .kill_i    (kill),
    .core_en_o (core_en),
    .busy_o    (busy),
    .step_o    (step),
    .step_idx_o(step_idx),
    .step_on_o (step_on)
  );

  always #5 clk = ~clk;

  // Cycle k ends at the posedge at 10k+5; the negedge at 10k lies inside cycle k.
  function automatic int cyc();
    return int'($time / 10);
  endfunction

  // Reference model: a step may start in any cycle >= m_ready; a step in cycle c
  // makes the block busy for cycles c+1 .. c+GAP.
  logic [NC-1:0] m_en    = '0;
  logic          m_step  = 1'b0;
  int            m_idx   = 0;
  logic          m_on    = 1'b0;
  int            m_ready = 0;

  always @(posedge clk or posedge rst) begin : model
    int unsigned d, e, pick;
    if (rst) begin
      m_en = '0; m_step = 1'b0; m_idx = 0; m_on = 1'b0; m_ready = 0;
    end else if (kill) begin
      m_en = '0; m_step = 1'b0; m_ready = cyc() + 1;
    end else begin
      m_step = 1'b0;
      d = 32'(m_en & ~target);
      e = 32'(~m_en & target);
      if (cyc() >= m_ready && !hold && (d | e) != 0) begin
        pick    = (d != 0) ? d : e;
        pick    = pick & (~pick + 1);
        m_idx   = $clog2(pick);
        m_on    = (d == 0);
        m_en    = m_en ^ pick[NC-1:0];
        m_step  = 1'b1;
        m_ready = cyc() + 1 + int'(GAP);
      end
    end
  end

  // Hand-computed expectations {en, busy, step, idx, on}, written only by stimulus.
  int         lit_cyc[48];
  logic [8:0] lit_val[48];
  int         n_lit = 0;
  logic       done  = 1'b0;

  task automatic add_lit(input int c, input logic [3:0] en, input logic b, input logic s,
                         input logic [1:0] idx, input logic on);
    lit_cyc[n_lit] = c;
    lit_val[n_lit] = {en, b, s, idx, on};
    n_lit++;
  endtask

  int n_chk   = 0;
  int n_pass  = 0;
  int lit_hit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc(), act, exp);
  endtask

  function automatic logic [8:0] dut_vec();
    return {core_en, busy, step, step_idx, step_on};
  endfunction

  function automatic logic [8:0] model_vec();
    logic [1:0] idx;
    idx = m_idx[1:0];
    return {m_en, (cyc() < m_ready), m_step, idx, m_on};
  endfunction

  // Single compare process: model every negedge, literals on their cycle,
  // and an immediate check when reset rises between clock edges.
  always @(negedge clk or posedge rst) begin
    if (clk) begin
      #1;
      chk("async_rst", {26'd0, core_en, busy, step}, 32'd0);
      chk("model_async", {23'd0, dut_vec()}, {23'd0, model_vec()});
    end else if ($time != 0) begin
      chk("model", {23'd0, dut_vec()}, {23'd0, model_vec()});
      for (int i = 0; i < n_lit; i++) begin
        if (lit_cyc[i] == cyc()) begin
          chk($sformatf("lit%0d", i), {23'd0, dut_vec()}, {23'd0, lit_val[i]});
          lit_hit++;
        end
      end
      if (done) begin
        chk("lits_visited", lit_hit, n_lit);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t, r;
    nx(3);
    rst = 1'b0;
    add_lit(cyc() + 1, 4'b0000, 0, 0, 2'd0, 0);
    nx(2);

    // Bring-up 0000 -> 1111
    t = cyc();
    target = 4'b1111;
    add_lit(t + 1,  4'b0001, 1, 1, 2'd0, 1);
    add_lit(t + 2,  4'b0001, 1, 0, 2'd0, 1);
    add_lit(t + 9,  4'b0001, 0, 0, 2'd0, 1);
    add_lit(t + 10, 4'b0011, 1, 1, 2'd1, 1);
    add_lit(t + 19, 4'b0111, 1, 1, 2'd2, 1);
    add_lit(t + 27, 4'b0111, 0, 0, 2'd2, 1);
    add_lit(t + 28, 4'b1111, 1, 1, 2'd3, 1);
    add_lit(t + 36, 4'b1111, 0, 0, 2'd3, 1);
    nx(40);

    // Reach 0101, then request 1010: disables first, lowest index first
    t = cyc();
    target = 4'b0101;
    add_lit(t + 1,  4'b1101, 1, 1, 2'd1, 0);
    add_lit(t + 10, 4'b0101, 1, 1, 2'd3, 0);
    nx(20);
    t = cyc();
    target = 4'b1010;
    add_lit(t + 1,  4'b0100, 1, 1, 2'd0, 0);
    add_lit(t + 10, 4'b0000, 1, 1, 2'd2, 0);
    add_lit(t + 19, 4'b0010, 1, 1, 2'd1, 1);
    add_lit(t + 28, 4'b1010, 1, 1, 2'd3, 1);
    add_lit(t + 36, 4'b1010, 0, 0, 2'd3, 1);
    nx(40);

    // Bit3 glitches 0->1->0 during WAIT: no further step
    t = cyc();
    target = 4'b0010;
    add_lit(t + 1,  4'b0010, 1, 1, 2'd3, 0);
    add_lit(t + 10, 4'b0010, 0, 0, 2'd3, 0);
    add_lit(t + 13, 4'b0010, 0, 0, 2'd3, 0);
    nx(3);
    target = 4'b1010;
    nx(2);
    target = 4'b0010;
    nx(9);

    // Kill for one cycle mid-WAIT with 0011 enabled, then re-ramp
    t = cyc();
    target = 4'b1111;
    add_lit(t + 1,  4'b0011, 1, 1, 2'd0, 1);
    add_lit(t + 5,  4'b0000, 0, 0, 2'd0, 1);
    add_lit(t + 6,  4'b0001, 1, 1, 2'd0, 1);
    add_lit(t + 15, 4'b0011, 1, 1, 2'd1, 1);
    add_lit(t + 33, 4'b1111, 1, 1, 2'd3, 1);
    add_lit(t + 41, 4'b1111, 0, 0, 2'd3, 1);
    nx(4);
    kill = 1'b1;
    nx(1);
    kill = 1'b0;
    nx(40);

    // Hold across the WAIT->IDLE boundary
    t = cyc();
    target = 4'b0000;
    add_lit(t + 1,  4'b1110, 1, 1, 2'd0, 0);
    add_lit(t + 12, 4'b1110, 0, 0, 2'd0, 0);
    add_lit(t + 14, 4'b1110, 0, 0, 2'd0, 0);
    add_lit(t + 15, 4'b1100, 1, 1, 2'd1, 0);
    nx(8);
    hold = 1'b1;
    nx(6);
    hold = 1'b0;
    nx(3);

    // Asynchronous reset between edges during WAIT
    @(posedge clk);
    #2;
    rst = 1'b1;
    nx(2);
    rst = 1'b0;

    // Kill together with hold beats a pending step
    r = cyc();
    target = 4'b0101;
    kill = 1'b1;
    hold = 1'b1;
    add_lit(r + 1, 4'b0000, 0, 0, 2'd0, 0);
    nx(1);
    kill = 1'b0;
    hold = 1'b0;
    add_lit(r + 2,  4'b0001, 1, 1, 2'd0, 1);
    add_lit(r + 11, 4'b0101, 1, 1, 2'd2, 1);
    nx(25);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc());
    $fatal(1, "watchdog expired");
  end

endmodule
